// File: rtl/counter_pkg.sv
// Shared encodings for the counter family: count direction and boundary behaviour.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/mod_counter_prescaler.sv
// Enable-gated prescaler: emits a tick every presc+1 enabled cycles.
module prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sync_clr,
  input  logic [PRESCALE_W-1:0] presc,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_reg;

  // A clear/load cycle never ticks, so the counter step is suppressed with it.
  assign tick = en && !sync_clr && (cnt_reg == presc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (sync_clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      if (tick) cnt_reg <= '0;
      else      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Programmable-modulo up/down counter with wrap/saturate, prescaler, load and tc/ovf flags.
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] presc,
  input  logic                  ovf_clr,
  output logic [WIDTH-1:0]      q,
  output logic                  tc,
  output logic                  ovf
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             tc_reg;
  logic             ovf_reg;
  logic             hit;
  logic             tick;

  prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (clr | load),
    .presc    (presc),
    .tick     (tick)
  );

  // q above limit counts as a boundary when stepping up, so loads and lowered limits recover.
  always_comb begin
    q_next = q_reg;
    hit    = 1'b0;
    if (dir == DIR_UP) begin
      if (q_reg >= limit) begin
        hit    = 1'b1;
        q_next = (mode == MODE_SAT) ? limit : '0;
      end else begin
        q_next = q_reg + 1'b1;
      end
    end else begin
      if (q_reg == '0) begin
        hit    = 1'b1;
        q_next = (mode == MODE_SAT) ? '0 : limit;
      end else begin
        q_next = q_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg   <= '0;
      tc_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      tc_reg <= 1'b0;
      if (clr) begin
        q_reg <= '0;
      end else if (load) begin
        q_reg <= load_val;
      end else if (tick) begin
        q_reg  <= q_next;
        tc_reg <= hit;
      end
      if (tick && hit)  ovf_reg <= 1'b1;
      else if (ovf_clr) ovf_reg <= 1'b0;
    end
  end

  assign q   = q_reg;
  assign tc  = tc_reg;
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_mod_counter.sv
// Directed scoreboard bench for mod_counter: 4-bit instance for the main plan, 8-bit for width.
module tb_mod_counter;
  import counter_pkg::*;

  typedef struct {
    string      tag;
    bit         sel;
    logic [7:0] q;
    logic       tc;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, clr, load, dir, mode, ovf_clr;
  logic [3:0] load_val, limit;
  logic [7:0] presc;
  logic [3:0] q4;
  logic       tc4, ovf4;

  logic       en8, clr8, load8, dir8, mode8, ovf_clr8;
  logic [7:0] load_val8, limit8, presc8;
  logic [7:0] q8;
  logic       tc8, ovf8;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .PRESCALE_W(8)) dut4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .mode(mode), .limit(limit), .presc(presc), .ovf_clr(ovf_clr),
    .q(q4), .tc(tc4), .ovf(ovf4)
  );

  mod_counter #(.WIDTH(8), .PRESCALE_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .clr(clr8), .load(load8), .load_val(load_val8),
    .dir(dir8), .mode(mode8), .limit(limit8), .presc(presc8), .ovf_clr(ovf_clr8),
    .q(q8), .tc(tc8), .ovf(ovf8)
  );

  task automatic push(input string tag, input logic [7:0] eq, input logic etc,
                      input logic eovf, input bit sel);
    exp_t e;
    e.tag = tag; e.sel = sel; e.q = eq; e.tc = etc; e.ovf = eovf;
    exp_q.push_back(e);
  endtask

  task automatic check();
    exp_t       e;
    logic [7:0] aq;
    logic       atc, aovf;
    e    = exp_q.pop_front();
    aq   = e.sel ? q8 : {4'b0, q4};
    atc  = e.sel ? tc8 : tc4;
    aovf = e.sel ? ovf8 : ovf4;
    vectors++;
    assert (aq === e.q && atc === e.tc && aovf === e.ovf) else begin
      miscompares++;
      $error("FAIL %s: got q=%0d tc=%b ovf=%b, expected q=%0d tc=%b ovf=%b",
             e.tag, aq, atc, aovf, e.q, e.tc, e.ovf);
    end
  endtask

  // Expectation is queued with the stimulus, then checked 1 ns after the edge.
  task automatic cyc(input string tag, input logic [7:0] eq, input logic etc,
                     input logic eovf, input bit sel = 1'b0);
    push(tag, eq, etc, eovf, sel);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;
    dir = DIR_UP; mode = MODE_WRAP; limit = 4'd9; presc = 8'd0; ovf_clr = 1'b0;
    en8 = 1'b0; clr8 = 1'b0; load8 = 1'b0; load_val8 = 8'd0; dir8 = DIR_UP;
    mode8 = MODE_WRAP; limit8 = 8'd255; presc8 = 8'd0; ovf_clr8 = 1'b0;

    #2;
    push("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    check();
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: wrap up, limit 9
    en = 1'b1;
    for (int i = 1; i <= 9; i++) cyc("wrap_up", i[7:0], 1'b0, 1'b0);
    cyc("wrap_up_hit", 8'd0, 1'b1, 1'b1);
    cyc("wrap_up_after", 8'd1, 1'b0, 1'b1);
    cyc("wrap_up_after", 8'd2, 1'b0, 1'b1);

    // 2: saturate down, ovf set beats ovf_clr
    load = 1'b1; load_val = 4'd2;
    cyc("load2", 8'd2, 1'b0, 1'b1);
    load = 1'b0; en = 1'b0; ovf_clr = 1'b1;
    cyc("ovf_clr", 8'd2, 1'b0, 1'b0);
    ovf_clr = 1'b0; en = 1'b1; mode = MODE_SAT; dir = DIR_DOWN;
    cyc("sat_dn", 8'd1, 1'b0, 1'b0);
    cyc("sat_dn", 8'd0, 1'b0, 1'b0);
    cyc("sat_dn_hit1", 8'd0, 1'b1, 1'b1);
    ovf_clr = 1'b1;
    cyc("sat_dn_hit2_setwins", 8'd0, 1'b1, 1'b1);
    en = 1'b0;
    cyc("ovf_clr2", 8'd0, 1'b0, 1'b0);
    ovf_clr = 1'b0;

    // 3: prescaler presc=3 with an enable gap mid-period
    mode = MODE_WRAP; dir = DIR_UP; presc = 8'd3; en = 1'b1; clr = 1'b1;
    cyc("clr", 8'd0, 1'b0, 1'b0);
    clr = 1'b0;
    for (int c = 1; c <= 12; c++) cyc("presc", 8'(c / 4), 1'b0, 1'b0);
    cyc("presc_p1", 8'd3, 1'b0, 1'b0);
    cyc("presc_p2", 8'd3, 1'b0, 1'b0);
    en = 1'b0;
    for (int c = 0; c < 5; c++) cyc("presc_hold", 8'd3, 1'b0, 1'b0);
    en = 1'b1;
    cyc("presc_resume", 8'd3, 1'b0, 1'b0);
    cyc("presc_tick", 8'd4, 1'b0, 1'b0);

    // 4: priority, then out-of-range load
    presc = 8'd0; clr = 1'b1; load = 1'b1; load_val = 4'd7;
    cyc("prio_clr", 8'd0, 1'b0, 1'b0);
    clr = 1'b0; load_val = 4'd12;
    cyc("load_oor", 8'd12, 1'b0, 1'b0);
    load = 1'b0;
    cyc("oor_up_hit", 8'd0, 1'b1, 1'b1);

    // 5: async reset with prescaler at 2
    load = 1'b1; load_val = 4'd5;
    cyc("load5", 8'd5, 1'b0, 1'b1);
    load = 1'b0; presc = 8'd3;
    cyc("pre_rst", 8'd5, 1'b0, 1'b1);
    cyc("pre_rst", 8'd5, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    push("async_rst", 8'd0, 1'b0, 1'b0, 1'b0);
    check();
    #1 rst = 1'b0;
    cyc("post_rst", 8'd0, 1'b0, 1'b0);
    cyc("post_rst", 8'd0, 1'b0, 1'b0);
    cyc("post_rst", 8'd0, 1'b0, 1'b0);
    cyc("post_rst_tick", 8'd1, 1'b0, 1'b0);
    en = 1'b0;

    // 6: 8-bit wrap at 255
    load8 = 1'b1; load_val8 = 8'd254;
    cyc("w8_load", 8'd254, 1'b0, 1'b0, 1'b1);
    load8 = 1'b0; en8 = 1'b1;
    cyc("w8_up", 8'd255, 1'b0, 1'b0, 1'b1);
    cyc("w8_wrap", 8'd0, 1'b1, 1'b1, 1'b1);
    cyc("w8_after", 8'd1, 1'b0, 1'b1, 1'b1);
    en8 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised synchronous up/down counter, successor to the 4-bit level-sensitive latch counter. Adds a clock, a programmable terminal value (modulo), a wrap or saturate mode, a prescaler, a parallel load and registered terminal-count/overflow flags. It is the general-purpose event/tick counter for timers, divided-clock enables and rate limiters in the SoC.

## Interface
- `WIDTH`, 4: counter width in bits.
- `PRESCALE_W`, 8: prescaler width in bits. The division ratio is `presc + 1`.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable, sampled synchronously. When low, the prescaler and the counter hold.
- `clr`  in  1  synchronous clear of the counter and the prescaler.
- `load`  in  1  synchronous parallel load of `load_val`; also clears the prescaler.
- `load_val`  in  WIDTH  value to load.
- `dir`  in  1  1 = count up, 0 = count down.
- `mode`  in  1  0 = wrap, 1 = saturate.
- `limit`  in  WIDTH  terminal value. The count range is 0..`limit`.
- `presc`  in  PRESCALE_W  prescale ratio minus one.
- `ovf_clr`  in  1  clears the sticky overflow flag.
- `q`  out  WIDTH  counter value.
- `tc`  out  1  one-cycle pulse when a step hits a boundary.
- `ovf`  out  1  sticky flag, set on every boundary hit.

## Operation
- **Reset:** `q`=0, `tc`=0, `ovf`=0, prescaler=0.
- **Priority per cycle:** `rst` > `clr` > `load` > count step.
- **`clr`:** sets `q`=0 and prescaler=0. Does not assert `tc` and does not change `ovf`.
- **`load`:** sets `q`=`load_val` and prescaler=0. Does not assert `tc`.
- **Prescaler:** advances only when `en`=1 and neither `clr` nor `load` is active. `tick` = `en` && (prescaler == `presc`). On a tick the prescaler returns to 0. With `presc`=0, every enabled cycle is a tick.
- **Step on tick, up (`dir`=1):**
  - `q` < `limit`: `q`+1.
  - `q` ≥ `limit`: wrap mode → 0; saturate mode → `limit`. This is a boundary hit.
- **Step on tick, down (`dir`=0):**
  - `q` > 0: `q`−1.
  - `q` == 0: wrap mode → `limit`; saturate mode → 0. This is a boundary hit.
- **Boundary hit:** `tc`=1 for the next cycle and `ovf` is set.
  - In saturate mode, a hit is reported on every tick while held at the boundary.
- **Out-of-range values:** `q` > `limit` can arise after a load or after `limit` is lowered.
  - Up: the next tick is a boundary hit and takes the wrap/saturate action above.
  - Down: decrements normally.
- **Arithmetic:** unsigned, modulo 2^WIDTH internally. Overflow past 2^WIDTH−1 cannot occur because `limit` ≤ 2^WIDTH−1.
- **`ovf`:** cleared by `ovf_clr`. If `ovf_clr` and a boundary hit occur in the same cycle, the set wins.
- **Quasi-static controls:** changes to `limit`, `mode`, `dir` and `presc` take effect on the next tick with no resynchronisation.
  - If `presc` is lowered below the current prescaler value, the prescaler counts up through wrap-around at 2^PRESCALE_W before the next tick. This is acceptable behaviour.

## Timing
- **Latency:** a step sampled on edge N is visible on `q` after edge N.
- **Flags:** `tc` and `ovf` are registered and update on the same edge as `q`. `tc` is high for exactly one cycle per hit.
- **Step rate:** with `en` held high, one step every `presc`+1 cycles. The first tick after reset, `clr` or `load` comes `presc`+1 enabled cycles later.
- **Mid-operation reset:** `rst` asserted at any time forces the reset values immediately (asynchronously). Counting resumes on the first edge after `rst` is released.
- **Combinational paths:** none from inputs to outputs.

## Structure
- **Shared package `counter_pkg`:**
  - `MODE_WRAP`=1'b0, `MODE_SAT`=1'b1.
  - `DIR_DOWN`=1'b0, `DIR_UP`=1'b1.
- **Sub-module `prescaler`:**
  - Parameter: `PRESCALE_W`.
  - Ports: `clk`, `rst`, `en`, `sync_clr`, `presc`, `tick`.
  - Instantiated once. `sync_clr` = `clr` | `load`.
- **Top level:** next-state logic for `q`, and the `tc`/`ovf` registers.

## Test plan
1. **Wrap up:** WIDTH=4, `limit`=9, `presc`=0, wrap mode, up, `en`=1 for 12 cycles → `q` = 1..9, 0, 1, 2. `tc` pulses once, on the edge where `q` goes to 0. `ovf`=1.
2. **Saturate down:** `load_val`=2, then saturate mode, down, `en`=1 for 4 cycles → `q` = 1, 0, 0, 0. `tc` is high for 2 cycles. Assert `ovf_clr` on the same cycle as the second hit → `ovf` stays 1.
3. **Prescaler:** `presc`=3, `en`=1 for 12 cycles → `q` increments only on cycles 4, 8 and 12. Drop `en` for 5 cycles mid-period → the prescaler and `q` hold.
4. **Priority:** `clr`, `load` (`load_val`=7) and a tick all in one cycle → `q`=0, `tc`=0. Then `load`=1 with `load_val`=12 and `limit`=9 → `q`=12. Next up tick → `q`=0 and `tc`=1.
5. **Reset mid-count:** with `q`=5, `ovf`=1 and prescaler=2 (`presc`=3), assert `rst` asynchronously between edges → `q`=0, `tc`=0 and `ovf`=0 immediately. After release, the first tick comes 4 cycles later.
6. **Width:** WIDTH=8, `limit`=255, wrap mode, up, starting from `q`=254 → `q` = 255, 0, and `tc` pulses on the wrap.
